div3_serial_rx: RTL and testbench
=================================

Name: div3_serial_rx

Overview:
- Bit-serial front end for the divisible-by-3 checker path.
- Deserialises DATA_W-bit words arriving MSB-first and tracks the residue mod 3 on the fly with a 3-state remainder FSM.
- Presents the assembled word, its residue and a divisibility flag over a valid/ready handshake, so downstream logic can consume word and flag together.

Parameters:
- DATA_W, 8, word width in bits; legal range 2..32.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- bit_in  in  1  serial data bit, MSB of the word first
- bit_valid  in  1  bit_in is valid this cycle
- frame_start  in  1  qualifies the current valid bit as the MSB of a new word
- bit_ready  out  1  block accepts a bit this cycle
- word_out  out  DATA_W  assembled word
- rem_out  out  2  word mod 3 (0..2)
- divisible  out  1  1 when rem_out == 0
- out_valid  out  1  word_out/rem_out/divisible are valid
- out_ready  in  1  downstream accepts the result
- sync_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset is synchronous: rst_n low at a clk edge puts the block in IDLE. Outputs after that edge: out_valid=0, word_out=0, rem_out=0, divisible=1 (follows rem_out), sync_err=0, bit count=0.
- Reset mid-frame or while in HOLD discards the partial or pending word. No out_valid is produced for it.
- A bit is accepted when bit_valid && bit_ready.
- bit_ready = (state != HOLD) || out_ready.
- Control states:
  - IDLE: an accepted bit with frame_start=1 loads shift = {0..0, bit_in}, rem = bit_in, cnt = 1, then goes to SHIFT. An accepted bit with frame_start=0 is dropped and sync_err pulses.
  - SHIFT: an accepted bit with frame_start=0 does shift = {shift[DATA_W-2:0], bit_in}, rem = (2*rem + bit_in) mod 3, cnt++.
    - When this is bit number DATA_W, go to HOLD.
    - An accepted bit with frame_start=1 in SHIFT is a framing error: sync_err pulses, the partial word is discarded, and the bit starts a new word exactly as in IDLE. Stay in SHIFT.
    - If DATA_W == 1 were allowed this would be ambiguous, hence DATA_W >= 2.
  - HOLD: out_valid=1; word_out, rem_out and divisible are stable until the handshake.
    - On out_valid && out_ready: out_valid drops next cycle.
    - A bit with frame_start=1 accepted in the same cycle starts a new word (HOLD -> SHIFT), giving back-to-back frames with no bubble.
    - With no such bit, go to IDLE.
    - A bit with frame_start=0 accepted in that same cycle is dropped and sync_err pulses, as in IDLE.
- Remainder FSM encoding R0=0, R1=1, R2=2. Transitions:
  - bit 0: R0->R0, R1->R2, R2->R1
  - bit 1: R0->R1, R1->R0, R2->R2
- Latency: out_valid rises on the clk edge after the cycle the last (DATA_W-th) bit is accepted. word_out, rem_out and divisible are registered and valid from that same edge.
- word_out is updated only on entry to HOLD. It does not change while out_valid is high, even if bit_in toggles.
- sync_err is registered: high for exactly one cycle after the offending accept.
- bit_valid low inside SHIFT stalls the frame indefinitely. There is no timeout.

Decomposition:
- Shared package div3_pkg holds:
  - control-state enum ST_IDLE/ST_SHIFT/ST_HOLD
  - remainder constants REM_0/REM_1/REM_2 (2 bits)
  - count width function CNT_W = $clog2(DATA_W+1)
- One natural combinational sub-module: div3_rem_step. Inputs rem[1:0] and bit. Output next rem per the table above. It is reused by future serial checkers.

Test Plan:
- Reset then serial 0x21 (33) with frame_start on the MSB, out_ready=1 -> one cycle after bit 8: out_valid=1, word_out=0x21, rem_out=0, divisible=1.
- Frames 0x05, 0x80, 0x7F, 0xFF -> rem_out 2, 2, 1, 0 and divisible 0, 0, 0, 1 respectively. word_out matches each frame.
- out_ready=0 for 5 cycles after 0xFF completes -> out_valid held, bit_ready=0, word_out stable at 0xFF. Raise out_ready together with frame_start and the MSB of 0x03 -> 0x03 is accepted with no bubble and yields rem_out=0.
- frame_start asserted again on bit 4 of a frame -> sync_err high one cycle, partial word dropped, following 8 bits form 0x02 -> rem_out=2, divisible=0.
- Valid bit without frame_start in IDLE -> sync_err pulse, state stays IDLE, no out_valid.
- rst_n low for one cycle after bit 5 of a frame, then a full 0x09 frame -> only one out_valid, word_out=0x09, divisible=1.

Source files
------------

// File: rtl/div3_pkg.sv
// Shared types and constants for the serial divisible-by-3 checker path.
// Control states, remainder encodings and the bit-count width helper.
package div3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] REM_0 = 2'd0;
    localparam logic [1:0] REM_1 = 2'd1;
    localparam logic [1:0] REM_2 = 2'd2;

    // Width of a counter that must reach data_w inclusive.
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/div3_rem_step.sv
// One step of the mod-3 remainder FSM: next = (2*rem + bit) mod 3.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module div3_rem_step
    import div3_pkg::*;
(
    input  logic [1:0] rem,
    input  logic       bit_in,
    output logic [1:0] rem_next
);

    always_comb begin
        rem_next = REM_0;
        unique case ({rem, bit_in})
            {REM_0, 1'b0}: rem_next = REM_0;
            {REM_0, 1'b1}: rem_next = REM_1;
            {REM_1, 1'b0}: rem_next = REM_2;
            {REM_1, 1'b1}: rem_next = REM_0;
            {REM_2, 1'b0}: rem_next = REM_1;
            {REM_2, 1'b1}: rem_next = REM_2;
            default:       rem_next = REM_0;
        endcase
    end

endmodule

// File: rtl/div3_serial_rx.sv
// MSB-first deserialiser tracking the word's residue mod 3 as bits arrive.
// Latency: result valid on the edge after the last bit is accepted.
// Backpressure: bit_ready drops while a result is held and out_ready is low.
module div3_serial_rx
    import div3_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              frame_start,
    output logic              bit_ready,
    output logic [DATA_W-1:0] word_out,
    output logic [1:0]        rem_out,
    output logic              divisible,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sync_err
);

    localparam int CNT_W = cnt_w(DATA_W);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [DATA_W-1:0] word_q, word_nxt;
    logic [1:0]        rem_q, rem_nxt;
    logic [1:0]        rem_out_q, rem_out_nxt;
    logic [1:0]        rem_src, rem_step;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              sync_err_q, err_nxt;
    logic              accept;

    assign bit_ready = (state != ST_HOLD) || out_ready;
    assign accept    = bit_valid && bit_ready;

    // A frame-start bit restarts the residue from zero, so one stepper covers both cases.
    assign rem_src = frame_start ? REM_0 : rem_q;

    div3_rem_step u_rem_step (
        .rem      (rem_src),
        .bit_in   (bit_in),
        .rem_next (rem_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift_q    <= '0;
            word_q     <= '0;
            rem_q      <= REM_0;
            rem_out_q  <= REM_0;
            cnt_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            word_q     <= word_nxt;
            rem_q      <= rem_nxt;
            rem_out_q  <= rem_out_nxt;
            cnt_q      <= cnt_nxt;
            sync_err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        word_nxt    = word_q;
        rem_nxt     = rem_q;
        rem_out_nxt = rem_out_q;
        cnt_nxt     = cnt_q;
        err_nxt     = 1'b0;

        if (state == ST_HOLD && out_ready) begin
            state_nxt = ST_IDLE;
        end

        if (accept) begin
            if (frame_start) begin
                err_nxt   = (state == ST_SHIFT);
                shift_nxt = {{(DATA_W-1){1'b0}}, bit_in};
                rem_nxt   = rem_step;
                cnt_nxt   = CNT_W'(1);
                state_nxt = ST_SHIFT;
            end else if (state == ST_SHIFT) begin
                shift_nxt = {shift_q[DATA_W-2:0], bit_in};
                rem_nxt   = rem_step;
                cnt_nxt   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    word_nxt    = {shift_q[DATA_W-2:0], bit_in};
                    rem_out_nxt = rem_step;
                    state_nxt   = ST_HOLD;
                end
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    assign out_valid = (state == ST_HOLD);
    assign word_out  = word_q;
    assign rem_out   = rem_out_q;
    assign divisible = (rem_out_q == REM_0);
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_div3_serial_rx.sv
// Randomised and directed bench for div3_serial_rx against an arithmetic frame model.
module tb_div3_serial_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, bit_in, bit_valid, frame_start, out_ready;
    logic         bit_ready, divisible, out_valid, sync_err;
    logic [W-1:0] word_out;
    logic [1:0]   rem_out;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_seen  = 0;

    // Reference model: frame progress as an integer value and a bit count.
    bit m_hold, m_inframe, m_err;
    int m_cnt, m_acc, m_out_word, m_out_rem;

    always #5 clk = ~clk;

    div3_serial_rx #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .bit_ready   (bit_ready),
        .word_out    (word_out),
        .rem_out     (rem_out),
        .divisible   (divisible),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sync_err    (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_inframe = 0; m_err = 0;
        m_cnt = 0; m_acc = 0; m_out_word = 0; m_out_rem = 0;
    endtask

    task automatic model_step(input logic r, bv, b, fs, ordy);
        bit acc, err;
        if (!r) begin
            model_reset();
            return;
        end
        acc = bv && (!m_hold || ordy);
        err = 0;
        if (m_hold && ordy) m_hold = 0;
        if (acc) begin
            if (fs) begin
                err = m_inframe;
                m_inframe = 1; m_acc = int'(b); m_cnt = 1;
            end else if (m_inframe) begin
                m_acc = m_acc * 2 + int'(b);
                m_cnt++;
                if (m_cnt == W) begin
                    m_inframe = 0; m_hold = 1;
                    m_out_word = m_acc; m_out_rem = m_acc % 3;
                end
            end else begin
                err = 1;
            end
        end
        m_err = err;
    endtask

    // One clock: drive, compare at the falling edge, advance model and clock.
    task automatic cycle(input logic r, bv, b, fs, ordy,
                         input bit chk = 0, input int ew = 0, input int er = 0);
        rst_n = r; bit_valid = bv; bit_in = b; frame_start = fs; out_ready = ordy;
        @(negedge clk);
        if (out_valid === 1'b1) ov_seen++;
        check("out_valid", out_valid, m_hold);
        check("word_out",  word_out,  m_out_word);
        check("rem_out",   rem_out,   m_out_rem);
        check("divisible", divisible, m_out_rem == 0);
        check("sync_err",  sync_err,  m_err);
        check("bit_ready", bit_ready, !m_hold || ordy);
        if (chk) begin
            check("res_valid", out_valid, 1);
            check("res_word",  word_out,  ew);
            check("res_rem",   rem_out,   er);
            check("res_div",   divisible, er == 0);
        end
        model_step(r, bv, b, fs, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] v, input logic ordy);
        logic [W-1:0] val;
        val = v;
        for (int i = W - 1; i >= 0; i--) cycle(1, 1, val[i], i == W - 1, ordy);
    endtask

    task automatic expect_result(input int ew, input int er);
        cycle(1, 0, 0, 0, 1, 1, ew, er);
    endtask

    initial begin
        model_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("rst_divisible", divisible, 1);
        check("rst_out_valid", out_valid, 0);

        send_frame(8'h21, 1); expect_result(8'h21, 0);
        send_frame(8'h05, 1); expect_result(8'h05, 2);
        send_frame(8'h80, 1); expect_result(8'h80, 2);
        send_frame(8'h7F, 1); expect_result(8'h7F, 1);
        send_frame(8'hFF, 1);

        // Stall the result while the next frame's MSB waits.
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 0, 1, 0, 1, 8'hFF, 0);
            check("stall_ready", bit_ready, 1'b0);
        end
        send_frame(8'h03, 1); expect_result(8'h03, 0);

        // Restart mid-frame: three bits, then a new frame-start on bit 4.
        cycle(1, 1, 1, 1, 1);
        cycle(1, 1, 1, 0, 1);
        cycle(1, 1, 0, 0, 1);
        send_frame(8'h02, 1); expect_result(8'h02, 2);

        // Stray bit in IDLE.
        cycle(1, 1, 1, 0, 1);
        cycle(1, 0, 0, 0, 1);
        check("idle_err_no_valid", out_valid, 0);

        // Reset after bit 5, then a full frame.
        ov_seen = 0;
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, i == 0, 1);
        cycle(0, 0, 0, 0, 1);
        send_frame(8'h09, 1); expect_result(8'h09, 0);
        cycle(1, 0, 0, 0, 1);
        check("single_valid", ov_seen, 1);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom), $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
